// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction memory request/response bus for the fetch stage
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [63:0] imem_rdata;
  logic        imem_valid;

  modport master (output imem_req, imem_addr, input imem_rdata, imem_valid);
  modport slave  (input imem_req, imem_addr, output imem_rdata, imem_valid);
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - dual-issue instruction fetch stage with single-pair buffer
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stallf,
  input  logic [1:0]          pcsrcd,
  input  logic [1:0]          pcsrcd2,
  input  logic [31:0]         targetd,
  input  logic [31:0]         targetd2,
  fetch_stage_if.master       imem,
  output logic [31:0]         pcf,
  output logic [31:0]         pcplus4f,
  output logic [31:0]         instrf,
  output logic [31:0]         instrf2,
  output logic                fetch_valid
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_FULL  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] stale_addr;
  logic [63:0] buf_data;

  logic        redir;
  logic        accept;
  logic [31:0] target;
  logic [31:0] pc_step;

  // Redirect decode: slot 1 is older, so its target wins when both resolve.
  always_comb begin
    redir   = (pcsrcd != 2'b00) | (pcsrcd2 != 2'b00);
    accept  = redir & ~stallf;
    target  = (pcsrcd != 2'b00) ? targetd : targetd2;
    pc_step = pc + (pc[2] ? 32'd4 : 32'd8);
  end

  // Fetch FSM: one outstanding request, responses to abandoned addresses are drained.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_REQ;
      pc         <= RESET_PC;
      stale_addr <= {RESET_PC[31:3], 3'b000};
      buf_data   <= '0;
    end else begin
      case (state)
        S_REQ: begin
          if (accept) begin
            pc <= target;
            if (imem.imem_valid) begin
              state <= S_REQ;
            end else begin
              // Request is still in flight; remember its address so the bus stays stable.
              stale_addr <= {pc[31:3], 3'b000};
              state      <= S_DRAIN;
            end
          end else if (imem.imem_valid) begin
            buf_data <= imem.imem_rdata;
            state    <= S_FULL;
          end
        end
        S_DRAIN: begin
          if (accept) begin
            pc <= target;
          end
          if (imem.imem_valid) begin
            state <= S_REQ;
          end
        end
        S_FULL: begin
          if (!stallf) begin
            pc    <= redir ? target : pc_step;
            state <= S_REQ;
          end
        end
        default: begin
          state <= S_REQ;
        end
      endcase
    end
  end

  // Output decode from state and buffer registers only.
  always_comb begin
    fetch_valid    = (state == S_FULL);
    imem.imem_req  = (state != S_FULL);
    imem.imem_addr = (state == S_DRAIN) ? stale_addr : {pc[31:3], 3'b000};
    pcf            = pc;
    pcplus4f       = pc + 32'd4;
    instrf         = NOP;
    instrf2        = NOP;
    if (state == S_FULL) begin
      if (pc[2]) begin
        instrf  = buf_data[63:32];
        instrf2 = NOP;
      end else begin
        instrf  = buf_data[31:0];
        instrf2 = buf_data[63:32];
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage
module tb_fetch_stage;
  localparam logic [31:0] NOPW = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        stallf;
  logic [1:0]  pcsrcd, pcsrcd2;
  logic [31:0] targetd, targetd2;
  logic [31:0] pcf, pcplus4f, instrf, instrf2;
  logic        fetch_valid;

  int total = 0;
  int bad = 0;
  int lat = 0;
  int wait_cnt = 0;

  fetch_stage_if imem_bus ();

  fetch_stage #(.RESET_PC(32'h0000_0000), .NOP(NOPW)) dut (
    .clk(clk), .reset(reset), .stallf(stallf),
    .pcsrcd(pcsrcd), .pcsrcd2(pcsrcd2), .targetd(targetd), .targetd2(targetd2),
    .imem(imem_bus),
    .pcf(pcf), .pcplus4f(pcplus4f), .instrf(instrf), .instrf2(instrf2),
    .fetch_valid(fetch_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h1111_1111;
    if (a == 32'h4) return 32'h2222_2222;
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  // Memory: answers after lat wait cycles, holds nothing across reset.
  always_comb begin
    imem_bus.imem_valid = imem_bus.imem_req && (wait_cnt >= lat);
    imem_bus.imem_rdata = {mem_word(imem_bus.imem_addr + 32'd4), mem_word(imem_bus.imem_addr)};
  end

  always @(posedge clk) begin
    if (reset) wait_cnt <= 0;
    else if (imem_bus.imem_req && imem_bus.imem_valid) wait_cnt <= 0;
    else if (imem_bus.imem_req) wait_cnt <= wait_cnt + 1;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_redirect;
    pcsrcd = 2'b00; pcsrcd2 = 2'b00; targetd = '0; targetd2 = '0;
  endtask

  task automatic test_reset;
    stallf = 0; clear_redirect(); lat = 0;
    reset = 1;
    step();
    total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", fetch_valid); end
    total++; if (instrf !== NOPW || instrf2 !== NOPW) begin bad++; $display("FAIL rst_instr got=%h/%h exp=%h", instrf, instrf2, NOPW); end
    total++; if (pcf !== 32'h0 || pcplus4f !== 32'h4) begin bad++; $display("FAIL rst_pc got=%h/%h exp=0/4", pcf, pcplus4f); end
    reset = 0;
    step();
  endtask

  task automatic test_zero_wait;
    reset = 1; step(); reset = 0;
    total++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h0) begin bad++; $display("FAIL zw_req got=%b/%h exp=1/0", imem_bus.imem_req, imem_bus.imem_addr); end
    step();
    total++; if (fetch_valid !== 1'b1) begin bad++; $display("FAIL zw_valid got=%b exp=1", fetch_valid); end
    total++; if (instrf !== 32'h1111_1111 || instrf2 !== 32'h2222_2222) begin bad++; $display("FAIL zw_instr got=%h/%h exp=11111111/22222222", instrf, instrf2); end
    total++; if (pcf !== 32'h0 || pcplus4f !== 32'h4) begin bad++; $display("FAIL zw_pc got=%h/%h exp=0/4", pcf, pcplus4f); end
    step();
    total++; if (imem_bus.imem_addr !== 32'h8 || fetch_valid !== 1'b0) begin bad++; $display("FAIL zw_next got=%h/%b exp=8/0", imem_bus.imem_addr, fetch_valid); end
    step();
    total++; if (pcf !== 32'h8 || fetch_valid !== 1'b1) begin bad++; $display("FAIL zw_pair2 got=%h/%b exp=8/1", pcf, fetch_valid); end
  endtask

  task automatic test_redirect_odd;
    pcsrcd = 2'b01; targetd = 32'h14;
    step(); clear_redirect();
    total++; if (imem_bus.imem_addr !== 32'h10 || fetch_valid !== 1'b0) begin bad++; $display("FAIL odd_addr got=%h/%b exp=10/0", imem_bus.imem_addr, fetch_valid); end
    step();
    total++; if (pcf !== 32'h14 || pcplus4f !== 32'h18) begin bad++; $display("FAIL odd_pc got=%h/%h exp=14/18", pcf, pcplus4f); end
    total++; if (instrf !== mem_word(32'h14) || instrf2 !== NOPW) begin bad++; $display("FAIL odd_instr got=%h/%h exp=%h/%h", instrf, instrf2, mem_word(32'h14), NOPW); end
    step();
    total++; if (imem_bus.imem_addr !== 32'h18) begin bad++; $display("FAIL odd_next got=%h exp=18", imem_bus.imem_addr); end
    step();
  endtask

  task automatic test_stall;
    stallf = 1; pcsrcd = 2'b01; targetd = 32'h80;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (pcf !== 32'h18 || fetch_valid !== 1'b1 || instrf !== mem_word(32'h18) || instrf2 !== mem_word(32'h1c) || pcplus4f !== 32'h1c) begin
        bad++; $display("FAIL stall_hold%0d got=%h/%b/%h/%h exp=18/1/%h/%h", i, pcf, fetch_valid, instrf, instrf2, mem_word(32'h18), mem_word(32'h1c));
      end
    end
    stallf = 0;
    step(); clear_redirect();
    total++; if (imem_bus.imem_addr !== 32'h80 || fetch_valid !== 1'b0) begin bad++; $display("FAIL stall_redir got=%h/%b exp=80/0", imem_bus.imem_addr, fetch_valid); end
    step();
    total++; if (pcf !== 32'h80 || fetch_valid !== 1'b1) begin bad++; $display("FAIL stall_after got=%h/%b exp=80/1", pcf, fetch_valid); end
  endtask

  task automatic test_drain;
    int n;
    lat = 2;
    step();
    total++; if (imem_bus.imem_addr !== 32'h88 || fetch_valid !== 1'b0) begin bad++; $display("FAIL drn_req got=%h/%b exp=88/0", imem_bus.imem_addr, fetch_valid); end
    step();
    pcsrcd = 2'b01; targetd = 32'h40;
    step(); clear_redirect();
    total++; if (imem_bus.imem_addr !== 32'h88 || imem_bus.imem_req !== 1'b1 || fetch_valid !== 1'b0) begin bad++; $display("FAIL drn_stale got=%h/%b/%b exp=88/1/0", imem_bus.imem_addr, imem_bus.imem_req, fetch_valid); end
    step();
    total++; if (imem_bus.imem_addr !== 32'h40 || fetch_valid !== 1'b0) begin bad++; $display("FAIL drn_new got=%h/%b exp=40/0", imem_bus.imem_addr, fetch_valid); end
    stallf = 1;
    n = 0;
    while (!fetch_valid && n < 10) begin step(); n++; end
    total++; if (n !== 3) begin bad++; $display("FAIL drn_latency got=%0d exp=3", n); end
    total++; if (pcf !== 32'h40 || instrf !== mem_word(32'h40) || instrf2 !== mem_word(32'h44)) begin bad++; $display("FAIL drn_pair got=%h/%h/%h exp=40/%h/%h", pcf, instrf, instrf2, mem_word(32'h40), mem_word(32'h44)); end
    stallf = 0; lat = 0;
  endtask

  task automatic test_priority;
    pcsrcd = 2'b10; targetd = 32'h100; pcsrcd2 = 2'b01; targetd2 = 32'h200;
    step(); clear_redirect();
    total++; if (imem_bus.imem_addr !== 32'h100) begin bad++; $display("FAIL prio_addr got=%h exp=100", imem_bus.imem_addr); end
    step();
    total++; if (pcf !== 32'h100 || fetch_valid !== 1'b1) begin bad++; $display("FAIL prio_pc got=%h/%b exp=100/1", pcf, fetch_valid); end
  endtask

  task automatic test_wrap;
    pcsrcd = 2'b11; targetd = 32'hFFFF_FFF8;
    step(); clear_redirect();
    total++; if (imem_bus.imem_addr !== 32'hFFFF_FFF8) begin bad++; $display("FAIL wrap_addr got=%h exp=fffffff8", imem_bus.imem_addr); end
    step();
    total++; if (pcf !== 32'hFFFF_FFF8 || pcplus4f !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_pc got=%h/%h exp=fffffff8/fffffffc", pcf, pcplus4f); end
    total++; if (instrf !== mem_word(32'hFFFF_FFF8) || instrf2 !== mem_word(32'hFFFF_FFFC)) begin bad++; $display("FAIL wrap_instr got=%h/%h exp=%h/%h", instrf, instrf2, mem_word(32'hFFFF_FFF8), mem_word(32'hFFFF_FFFC)); end
    step();
    total++; if (imem_bus.imem_addr !== 32'h0 || pcf !== 32'h0) begin bad++; $display("FAIL wrap_next got=%h/%h exp=0/0", imem_bus.imem_addr, pcf); end
  endtask

  task automatic test_reset_in_drain;
    int n;
    step();
    lat = 3;
    step();
    step();
    pcsrcd = 2'b01; targetd = 32'h300;
    step(); clear_redirect();
    reset = 1;
    step(); reset = 0;
    total++; if (fetch_valid !== 1'b0 || pcf !== 32'h0 || imem_bus.imem_addr !== 32'h0) begin bad++; $display("FAIL rstd_state got=%b/%h/%h exp=0/0/0", fetch_valid, pcf, imem_bus.imem_addr); end
    stallf = 1;
    n = 0;
    while (!fetch_valid && n < 10) begin step(); n++; end
    total++; if (pcf !== 32'h0 || instrf !== 32'h1111_1111 || fetch_valid !== 1'b1) begin bad++; $display("FAIL rstd_pair got=%h/%h/%b exp=0/11111111/1", pcf, instrf, fetch_valid); end
    stallf = 0; lat = 0;
  endtask

  task automatic test_random;
    logic [31:0] exp_pc;
    logic [31:0] h_pcf, h_i1, h_i2;
    logic        hold;
    int idle, max_idle, consumed;
    exp_pc = 32'h0; hold = 0; idle = 0; max_idle = 0; consumed = 0;
    h_pcf = '0; h_i1 = '0; h_i2 = '0;
    stallf = 0; clear_redirect();
    reset = 1; step(); reset = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc % 64 == 0) lat = $urandom_range(0, 3);
      if (fetch_valid) begin
        idle = 0;
        total++; if (pcf !== exp_pc || pcplus4f !== exp_pc + 32'd4) begin bad++; $display("FAIL rnd_pc cyc=%0d got=%h/%h exp=%h", cyc, pcf, pcplus4f, exp_pc); end
        total++;
        if (instrf !== mem_word(exp_pc) || instrf2 !== (exp_pc[2] ? NOPW : mem_word(exp_pc + 32'd4))) begin
          bad++; $display("FAIL rnd_instr cyc=%0d pc=%h got=%h/%h", cyc, exp_pc, instrf, instrf2);
        end
      end else begin
        idle++;
        if (idle > max_idle) max_idle = idle;
      end
      if (hold) begin
        total++; if (fetch_valid !== 1'b1 || pcf !== h_pcf || instrf !== h_i1 || instrf2 !== h_i2) begin bad++; $display("FAIL rnd_hold cyc=%0d got=%b/%h/%h/%h exp=1/%h/%h/%h", cyc, fetch_valid, pcf, instrf, instrf2, h_pcf, h_i1, h_i2); end
      end
      stallf   = ($urandom_range(0, 3) == 0);
      pcsrcd   = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      pcsrcd2  = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      targetd  = $urandom & 32'hFFFF_FFFC;
      targetd2 = $urandom & 32'hFFFF_FFFC;
      hold  = fetch_valid && stallf;
      h_pcf = pcf; h_i1 = instrf; h_i2 = instrf2;
      if (!stallf && (pcsrcd != 2'b00 || pcsrcd2 != 2'b00)) begin
        exp_pc = (pcsrcd != 2'b00) ? targetd : targetd2;
      end else if (fetch_valid && !stallf) begin
        exp_pc = exp_pc + (exp_pc[2] ? 32'd4 : 32'd8);
        consumed++;
      end
      step();
    end
    clear_redirect(); stallf = 0;
    total++; if (max_idle > 40) begin bad++; $display("FAIL rnd_progress got=%0d exp<=40", max_idle); end
    total++; if (consumed < 100) begin bad++; $display("FAIL rnd_consumed got=%0d exp>=100", consumed); end
  endtask

  initial begin
    reset = 1; stallf = 0; pcsrcd = 0; pcsrcd2 = 0; targetd = 0; targetd2 = 0;
    test_reset();
    test_zero_wait();
    test_redirect_odd();
    test_stall();
    test_drain();
    test_priority();
    test_wrap();
    test_reset_in_drain();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the dual-issue pipeline. It owns the PC register, issues 64-bit pair fetches to instruction memory, and buffers the returned pair. It presents `pcf`, `pcplus4f`, `instrf` and `instrf2` to the fetch/decode pipeline register, and redirects the PC on branch and jump resolution from either decode slot.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; must be 4-byte aligned.
- `NOP`, default 32'h0000_0000: word driven on `instrf`/`instrf2` when no valid instruction is available.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `stallf`  in  1  fetch/decode hold; same signal that stalls the fetch/decode register.
- `pcsrcd`  in  2  slot-1 redirect select from decode; nonzero means redirect.
- `pcsrcd2`  in  2  slot-2 redirect select; nonzero means redirect.
- `targetd`  in  32  slot-1 redirect target, 4-byte aligned.
- `targetd2`  in  32  slot-2 redirect target, 4-byte aligned.
- `imem_req`  out  1  fetch request; held high until `imem_valid`.
- `imem_addr`  out  32  `{pc[31:3],3'b000}`.
- `imem_rdata`  in  64  [31:0] = word at the aligned address; [63:32] = word at aligned address + 4.
- `imem_valid`  in  1  response for the outstanding request; may arrive in the request cycle or any later cycle.
- `pcf`  out  32  address of `instrf`.
- `pcplus4f`  out  32  `pcf + 4`, modulo 2^32.
- `instrf`  out  32  slot-1 instruction.
- `instrf2`  out  32  slot-2 instruction.
- `fetch_valid`  out  1  buffer holds a valid pair.

## Operation
- States: REQ, FULL, DRAIN.
  - REQ: waiting for the current pc's response.
  - FULL: buffer valid.
  - DRAIN: discarding a stale response.
- At most one request is outstanding. `imem_req` = 1 in REQ and DRAIN. `imem_addr` is driven from pc in REQ and from the stale address in DRAIN.
- Redirect condition `redir = (pcsrcd != 0) | (pcsrcd2 != 0)`. A redirect is accepted only when `stallf` = 0.
- Target priority: `pcsrcd` nonzero selects `targetd`; otherwise `targetd2` is used. Slot 1 is the older instruction.
- REQ:
  - On `imem_valid`, capture `imem_rdata` and pc into the buffer and go to FULL.
  - If an accepted redirect occurs in the same cycle, discard the data, set pc to the target, and go to REQ.
  - An accepted redirect without `imem_valid` sets pc to the target and goes to DRAIN.
- DRAIN: on `imem_valid`, discard the data and go to REQ with the new pc. A further accepted redirect in DRAIN only updates pc.
- FULL:
  - `stallf` = 1: hold everything.
  - `stallf` = 0 with redirect: set pc to the target, drop the buffer, go to REQ.
  - `stallf` = 0 without redirect: the pair is consumed; advance pc by 8 if pc[2] = 0, or by 4 if pc[2] = 1; go to REQ.
- Output mapping in FULL:
  - pc[2] = 0: `instrf` = rdata[31:0], `instrf2` = rdata[63:32].
  - pc[2] = 1 (odd-word entry after a redirect): `instrf` = rdata[63:32], `instrf2` = NOP.
- Outside FULL: `instrf` = `instrf2` = NOP, `fetch_valid` = 0, and `pcf` = pc.
- PC arithmetic wraps modulo 2^32.

## Timing
- Reset, at the sampling edge:
  - pc = RESET_PC, state = REQ, buffer invalid.
  - `instrf` = `instrf2` = NOP, `fetch_valid` = 0, `pcf` = RESET_PC, `pcplus4f` = RESET_PC + 4.
  - `imem_req` = 1 from the first cycle after reset.
- Instruction memory is reset by the same `reset`. Responses to requests issued before reset are never delivered.
- Reset during FULL or DRAIN discards all state.
- Zero-wait memory: the request cycle is captured at its edge, and outputs are valid in the next cycle. Throughput is one pair per 2 cycles.
- N-cycle memory: FULL is entered at edge N after the request. Outputs are combinational from the buffer and state registers only.
- A redirect accepted at edge E puts the new target on `imem_addr` in cycle E+1, unless the FSM is in DRAIN. In the same edge the fetch/decode register clears itself, so no stale pair is consumed.
- `imem_req` never drops while a response is outstanding.

## Test plan
- Reset then zero-wait memory returning {0x22222222, 0x11111111} at address 0:
  - `imem_addr` is 0 for the first cycle after reset.
  - Next cycle: `instrf` = 0x11111111, `instrf2` = 0x22222222, `pcf` = 0, `pcplus4f` = 4, `fetch_valid` = 1.
  - Following request is at 0x8.
- Redirect to 0x14 via `pcsrcd` = 2'b01, `targetd` = 0x14:
  - `imem_addr` = 0x10.
  - `instrf` = word at 0x14, `instrf2` = NOP, `pcf` = 0x14.
  - Next request at 0x18.
- `stallf` held 3 cycles while FULL: all outputs and pc are constant; a concurrent redirect is ignored until `stallf` drops.
- 3-cycle memory latency with a redirect to 0x40 in the second wait cycle:
  - State goes to DRAIN; the stale response is discarded.
  - Next `imem_addr` = 0x40; first valid `pcf` = 0x40.
- `pcsrcd` = 2'b10 with `targetd` = 0x100, and `pcsrcd2` = 2'b01 with `targetd2` = 0x200, in the same cycle: next fetch is at 0x100.
- PC = 0xFFFFFFF8, sequential advance: next pc = 0x00000000 (wrap), and `pcplus4f` = 0xFFFFFFFC while the old pair is displayed.
